// File: rtl/tl_arb_pkg.sv
// Shared types and helpers for the three-source channel arbiters.
// Provides the arbiter state encoding and the mod-3 pointer and one-hot helpers.
package tl_arb_pkg;

  localparam int N_SRC = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Advance a source index modulo 3; the unused code 3 folds back to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational priority-rotated picker: first valid source scanning prio,
// prio+1, prio+2 (mod 3). Shared by the channel arbiters.
module rr_pick3
  import tl_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] prio,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    logic [1:0] cand;
    logic       found;
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    idx   = 2'd0;
    found = 1'b0;
    cand  = (prio == 2'd3) ? 2'd0 : prio;
    for (int k = 0; k < 3; k++) begin
      if (!found && valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

  assign any = |valid;

endmodule

// File: rtl/tl_rr_arbiter3.sv
// Three-source round-robin arbiter with burst locking and zero-latency grant
// in front of a shared downstream channel.
module tl_rr_arbiter3
  import tl_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int N_SRC  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        in_valid,
  input  logic [N_SRC-1:0]        in_last,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  output logic [N_SRC-1:0]        in_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [DATA_W-1:0]       out_data,
  output logic [N_SRC-1:0]        out_sel,
  input  logic                    out_ready,
  output logic                    locked
);

  if (N_SRC != 3) begin : g_bad_n_src
    $error("tl_rr_arbiter3 supports N_SRC == 3 only");
  end

  arb_state_e state_q, state_d;
  logic [1:0] prio_q, prio_d;
  logic [1:0] lock_idx_q, lock_idx_d;
  logic       pend_q, pend_d;
  logic [1:0] pend_idx_q, pend_idx_d;

  logic [1:0] pick_idx;
  logic       pick_any;
  logic [1:0] cand_idx;
  logic [2:0] sel;
  logic       fire;

  rr_pick3 u_pick (
    .valid (in_valid),
    .prio  (prio_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A stalled IDLE candidate is held like a lock so a later, higher-priority
  // arrival cannot pre-empt a beat the downstream has already seen offered.
  assign cand_idx = pend_q ? pend_idx_q : pick_idx;

  always_comb begin
    sel = 3'b000;
    if (reset) begin
      sel = 3'b000;
    end else if (state_q == BURST) begin
      sel = onehot3(lock_idx_q);
    end else if (pend_q || pick_any) begin
      sel = onehot3(cand_idx);
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (sel[i]) out_data = out_data | in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_sel   = sel;
  assign out_valid = |(sel & in_valid);
  assign out_last  = |(sel & in_last);
  assign in_ready  = sel & {N_SRC{out_ready}};
  assign fire      = out_valid & out_ready;
  assign locked    = (state_q == BURST);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_idx_d = lock_idx_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          pend_d = 1'b0;
          if (out_last) begin
            prio_d = rr_next(cand_idx);
          end else begin
            state_d    = BURST;
            lock_idx_d = cand_idx;
          end
        end else if (out_valid) begin
          pend_d     = 1'b1;
          pend_idx_d = cand_idx;
        end
      end
      BURST: begin
        if (fire && out_last) begin
          state_d = IDLE;
          prio_d  = rr_next(lock_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 2'd0;
      lock_idx_q <= 2'd0;
      pend_q     <= 1'b0;
      pend_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_idx_q <= lock_idx_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

`ifndef SYNTHESIS
  always_comb begin
    assert ($onehot0(sel)) else $error("tl_rr_arbiter3: out_sel not one-hot: %b", sel);
  end
`endif

endmodule

// File: tb/tb_tl_rr_arbiter3.sv
// Directed-vector bench for tl_rr_arbiter3: reset, rotation, burst lock,
// backpressure stability, mid-burst stall and asynchronous reset mid-burst.
module tb_tl_rr_arbiter3;

  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] D0 = 64'hA0A0;
  localparam logic [DATA_W-1:0] D1 = 64'hB1B1;
  localparam logic [DATA_W-1:0] D2 = 64'hDEAD;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        in_valid;
  logic [2:0]        in_last;
  logic [3*DATA_W-1:0] in_data;
  logic [2:0]        in_ready;
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_sel;
  logic              out_ready;
  logic              locked;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  tl_rr_arbiter3 #(.DATA_W(DATA_W), .N_SRC(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .locked    (locked)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a vector at the falling edge and settle before sampling.
  task automatic apply(input logic [2:0] v, input logic [2:0] l, input logic r);
    @(negedge clock);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    #2;
  endtask

  initial begin
    logic [2:0] rot [6];
    rot = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    in_data   = {D2, D1, D0};
    reset     = 1'b1;
    in_valid  = 3'b000;
    in_last   = 3'b000;
    out_ready = 1'b0;

    // 1. reset
    #2;
    check("rst_sel",    out_sel,   3'b000);
    check("rst_valid",  out_valid, 1'b0);
    check("rst_ready",  in_ready,  3'b000);
    check("rst_locked", locked,    1'b0);
    in_valid = 3'b111;
    out_ready = 1'b1;
    #1;
    check("rst_sel_vld", out_sel, 3'b000);
    in_valid = 3'b000;
    @(negedge clock);
    reset = 1'b0;
    apply(3'b000, 3'b000, 1'b1);
    check("idle_sel",    out_sel,   3'b000);
    check("idle_valid",  out_valid, 1'b0);
    check("idle_ready",  in_ready,  3'b000);
    check("idle_locked", locked,    1'b0);

    // 2. fair rotation
    for (int i = 0; i < 6; i++) begin
      apply(3'b111, 3'b111, 1'b1);
      check($sformatf("rot%0d_sel", i), out_sel, rot[i]);
      check($sformatf("rot%0d_rdy", i), in_ready, rot[i]);
    end

    // 3. burst lock by src1 (advance prio to 1 first)
    apply(3'b001, 3'b001, 1'b1);
    check("pre_burst_sel", out_sel, 3'b001);
    apply(3'b011, 3'b000, 1'b1);
    check("b1_sel",    out_sel,  3'b010);
    check("b1_locked", locked,   1'b0);
    check("b1_data",   out_data, D1);
    for (int i = 2; i <= 3; i++) begin
      apply(3'b011, 3'b000, 1'b1);
      check($sformatf("b%0d_sel", i),    out_sel, 3'b010);
      check($sformatf("b%0d_locked", i), locked,  1'b1);
    end
    apply(3'b011, 3'b010, 1'b1);
    check("b4_sel",    out_sel,  3'b010);
    check("b4_last",   out_last, 1'b1);
    check("b4_locked", locked,   1'b1);
    apply(3'b111, 3'b111, 1'b0);
    check("post_burst_sel",    out_sel, 3'b100);
    check("post_burst_locked", locked,  1'b0);
    apply(3'b111, 3'b111, 1'b1);
    check("post_burst_fire", out_sel, 3'b100);

    // 4. backpressure stability, prio=0
    for (int i = 0; i < 3; i++) begin
      apply(3'b100, 3'b100, 1'b0);
      check($sformatf("bp%0d_sel", i),  out_sel,   3'b100);
      check($sformatf("bp%0d_data", i), out_data,  D2);
      check($sformatf("bp%0d_rdy", i),  in_ready,  3'b000);
    end
    apply(3'b101, 3'b101, 1'b0);
    check("bp_hold_sel",  out_sel,  3'b100);
    check("bp_hold_data", out_data, D2);
    apply(3'b101, 3'b101, 1'b1);
    check("bp_fire_sel", out_sel,  3'b100);
    check("bp_fire_rdy", in_ready, 3'b100);
    apply(3'b101, 3'b101, 1'b0);
    check("bp_after_sel",  out_sel,  3'b001);
    check("bp_after_data", out_data, D0);
    apply(3'b101, 3'b101, 1'b1);
    check("bp_after_fire", out_sel, 3'b001);

    // 5. mid-burst stall by src0, prio=1 so only src0 offered on beat 1
    apply(3'b001, 3'b000, 1'b1);
    check("st_b1_sel", out_sel, 3'b001);
    for (int i = 0; i < 2; i++) begin
      apply(3'b010, 3'b000, 1'b1);
      check($sformatf("st%0d_sel", i),    out_sel,   3'b001);
      check($sformatf("st%0d_valid", i),  out_valid, 1'b0);
      check($sformatf("st%0d_rdy1", i),   in_ready[1], 1'b0);
      check($sformatf("st%0d_locked", i), locked,    1'b1);
    end
    apply(3'b011, 3'b001, 1'b1);
    check("st_end_sel",  out_sel,  3'b001);
    check("st_end_last", out_last, 1'b1);

    // 6. async reset during beat 2 of a src1 burst
    apply(3'b010, 3'b000, 1'b1);
    check("ar_b1_sel", out_sel, 3'b010);
    apply(3'b010, 3'b000, 1'b1);
    check("ar_b2_locked", locked, 1'b1);
    reset    = 1'b1;
    in_valid = 3'b000;
    #1;
    check("ar_sel",    out_sel,   3'b000);
    check("ar_locked", locked,    1'b0);
    check("ar_valid",  out_valid, 1'b0);
    #1;
    reset = 1'b0;
    apply(3'b111, 3'b111, 1'b1);
    check("ar_first_sel",    out_sel, 3'b001);
    check("ar_first_locked", locked,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
